// File: rtl/ram_sdp_param_pkg.sv
// Shared types, constants and parameter checking for ram_sdp_param.
package ram_pkg;

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Returns the lane count, or 0 when the parameter set is not legal.
  function automatic int ram_calc_nb(int width, int byte_wd, int depth,
                                     int add_wd, int rd_lat);
    if (byte_wd <= 0 || (width % byte_wd) != 0) return 0;
    if (rd_lat < 1 || rd_lat > 2)               return 0;
    if ((1 << add_wd) < depth)                  return 0;
    return width / byte_wd;
  endfunction

endpackage

// File: rtl/ram_sdp_param_if.sv
// Write/read request bus of ram_sdp_param. RAM_SDP_PARITY_EN adds WrParInj/RdParErr.
interface ram_sdp_param_if #(
  parameter int WIDTH   = 16,
  parameter int BYTE_WD = 8,
  parameter int ADD_WD  = 3
);
  localparam int NB = WIDTH / BYTE_WD;

  logic              WrEn;
  logic [ADD_WD-1:0] WrAddr;
  logic [WIDTH-1:0]  WrData;
  logic [NB-1:0]     WrBe;
  logic              RdEn;
  logic [ADD_WD-1:0] RdAddr;
  logic [WIDTH-1:0]  RdData;
  logic              RdValid;
  logic              Busy;
`ifdef RAM_SDP_PARITY_EN
  logic              WrParInj;
  logic              RdParErr;

  modport master (output WrEn, WrAddr, WrData, WrBe, WrParInj, RdEn, RdAddr,
                  input  RdData, RdValid, Busy, RdParErr);
  modport slave  (input  WrEn, WrAddr, WrData, WrBe, WrParInj, RdEn, RdAddr,
                  output RdData, RdValid, Busy, RdParErr);
`else
  modport master (output WrEn, WrAddr, WrData, WrBe, RdEn, RdAddr,
                  input  RdData, RdValid, Busy);
  modport slave  (input  WrEn, WrAddr, WrData, WrBe, RdEn, RdAddr,
                  output RdData, RdValid, Busy);
`endif
endinterface

// File: rtl/ram_sdp_param_init_seq.sv
// Post-reset clear sweep: walks every word once, then holds READY until the next reset.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADD_WD = 3
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              o_busy,
  output logic [ADD_WD-1:0] o_swp_addr,
  output logic              o_swp_we
);

  state_t            r_state, w_state_nxt;
  logic [ADD_WD-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_swp_we    = 1'b0;
    case (r_state)
      INIT: begin
        o_swp_we = 1'b1;
        if (r_cnt == ADD_WD'(DEPTH - 1)) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_busy     = (r_state == INIT);
  assign o_swp_addr = r_cnt;

endmodule

// File: rtl/ram_sdp_param.sv
// Simple-dual-port RAM with byte enables, RD_LAT 1/2 read pipe and clear sweep.
// RAM_SDP_PARITY_EN adds per-lane even parity with injection and read-side checking.
module ram_sdp_param
  import ram_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int BYTE_WD  = 8,
  parameter int DEPTH    = 8,
  parameter int ADD_WD   = 3,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic            CLK,
  input  logic            RST,
  ram_sdp_param_if.slave  bus
);

  localparam int NB = ram_calc_nb(WIDTH, BYTE_WD, DEPTH, ADD_WD, RD_LAT);
  localparam logic [ADD_WD:0] DEPTH_A = (ADD_WD + 1)'(DEPTH);

  if (NB == 0) begin : g_param_err
    $error("ram_sdp_param: illegal WIDTH/BYTE_WD/DEPTH/ADD_WD/RD_LAT");
  end

  logic              w_busy, w_swp_we;
  logic [ADD_WD-1:0] w_swp_addr;

  ram_init_seq #(.DEPTH(DEPTH), .ADD_WD(ADD_WD)) u_init (
    .CLK        (CLK),
    .RST        (RST),
    .o_busy     (w_busy),
    .o_swp_addr (w_swp_addr),
    .o_swp_we   (w_swp_we)
  );

  logic w_rd_acc, w_wr_acc, w_rd_oor, w_coll;
  assign w_rd_acc = bus.RdEn & ~w_busy;
  assign w_wr_acc = bus.WrEn & ~w_busy & ({1'b0, bus.WrAddr} < DEPTH_A);
  assign w_rd_oor = ({1'b0, bus.RdAddr} >= DEPTH_A);
  assign w_coll   = w_wr_acc & (bus.WrAddr == bus.RdAddr);

  // The sweep owns the write port while busy; user writes are never accepted then.
  logic              w_we;
  logic [ADD_WD-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;
  logic [NB-1:0]     w_wbe;
  assign w_we    = w_swp_we | w_wr_acc;
  assign w_waddr = w_swp_we ? w_swp_addr : bus.WrAddr;
  assign w_wdata = w_swp_we ? '0 : bus.WrData;
  assign w_wbe   = w_swp_we ? '1 : bus.WrBe;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (w_we)
      for (int i = 0; i < NB; i++)
        if (w_wbe[i]) r_mem[w_waddr][i*BYTE_WD +: BYTE_WD] <= w_wdata[i*BYTE_WD +: BYTE_WD];
  end

  logic [WIDTH-1:0] w_old, w_merge, w_rd_word;
  assign w_old     = w_rd_oor ? '0 : r_mem[bus.RdAddr];
  assign w_rd_word = (RDW_MODE == RDW_WRITE_FIRST) ? w_merge : w_old;

`ifdef RAM_SDP_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_new_par, w_wpar, w_old_par, w_merge_par, w_rd_par, w_pchk;
  logic          w_perr;

  assign w_wpar = w_swp_we ? '0 : w_new_par;

  always_ff @(posedge CLK) begin
    if (w_we)
      for (int i = 0; i < NB; i++)
        if (w_wbe[i]) r_par[w_waddr][i] <= w_wpar[i];
  end

  assign w_old_par = w_rd_oor ? '0 : r_par[bus.RdAddr];
  assign w_rd_par  = (RDW_MODE == RDW_WRITE_FIRST) ? w_merge_par : w_old_par;
  assign w_perr    = ~w_rd_oor & (|w_pchk);
`endif

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign w_merge[i*BYTE_WD +: BYTE_WD] = (w_coll && bus.WrBe[i]) ?
        bus.WrData[i*BYTE_WD +: BYTE_WD] : w_old[i*BYTE_WD +: BYTE_WD];
`ifdef RAM_SDP_PARITY_EN
    assign w_new_par[i]   = (^bus.WrData[i*BYTE_WD +: BYTE_WD]) ^ bus.WrParInj;
    assign w_merge_par[i] = (w_coll && bus.WrBe[i]) ? w_new_par[i] : w_old_par[i];
    assign w_pchk[i]      = (^w_rd_word[i*BYTE_WD +: BYTE_WD]) ^ w_rd_par[i];
`endif
  end

  // Word is captured at the accept edge, so later writes cannot disturb an in-flight read.
  logic [RD_LAT:0]              r_vld_pipe;
  logic [RD_LAT-1:0][WIDTH-1:0] r_dat_pipe;
  logic [WIDTH-1:0]             r_rd_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
      r_rd_data  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_rd_acc};
      if (w_rd_acc) r_dat_pipe[0] <= w_rd_word;
      for (int k = 1; k < RD_LAT; k++) r_dat_pipe[k] <= r_dat_pipe[k-1];
      if (r_vld_pipe[RD_LAT-1]) r_rd_data <= r_dat_pipe[RD_LAT-1];
    end
  end

  assign bus.RdData  = r_rd_data;
  assign bus.RdValid = r_vld_pipe[RD_LAT];
  assign bus.Busy    = w_busy;

`ifdef RAM_SDP_PARITY_EN
  logic [RD_LAT-1:0] r_err_pipe;
  logic              r_rd_perr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err_pipe <= '0;
      r_rd_perr  <= 1'b0;
    end else begin
      r_err_pipe[0] <= w_rd_acc & w_perr;
      for (int k = 1; k < RD_LAT; k++) r_err_pipe[k] <= r_err_pipe[k-1];
      r_rd_perr <= r_vld_pipe[RD_LAT-1] & r_err_pipe[RD_LAT-1];
    end
  end

  assign bus.RdParErr = r_rd_perr;
`endif

endmodule

// File: doc/ram_sdp_param.md
Name: ram_sdp_param

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, shared clock.
- Successor to the fixed 16x8 single-address RAM.
- Adds:
  - independent read and write addresses
  - per-byte write enables
  - configurable read latency with a valid strobe
  - defined read-during-write behaviour
  - a post-reset clear sweep, so the array never needs an asynchronous reset.
- Used as the generic storage primitive under register files and buffers.

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of BYTE_WD.
- BYTE_WD, 8, bits per write-enable lane; lanes NB = WIDTH/BYTE_WD.
- DEPTH, 8, number of words; need not be a power of two.
- ADD_WD, 3, address width; must satisfy 2^ADD_WD >= DEPTH.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read/write collision: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- WrEn  in  1  write request.
- WrAddr  in  ADD_WD  write address.
- WrData  in  WIDTH  write data.
- WrBe  in  NB  byte-lane enables; lane i covers bits [i*BYTE_WD +: BYTE_WD].
- RdEn  in  1  read request.
- RdAddr  in  ADD_WD  read address.
- RdData  out  WIDTH  read data; holds its last value between reads.
- RdValid  out  1  one-cycle strobe, RdData updated this cycle.
- Busy  out  1  high while reset is asserted or the clear sweep is running.

Behaviour:
- Reset (RST=1, asynchronous): RdData=0, RdValid=0, Busy=1, read pipeline flushed, state=INIT, sweep counter=0. The array is not reset directly.
- FSM states are INIT and READY.
- INIT:
  - Each cycle after RST deasserts, word[cnt] is written with 0 and cnt increments.
  - After the cycle that writes DEPTH-1, go to READY; Busy falls on the following edge.
  - Sweep length is exactly DEPTH cycles.
  - WrEn and RdEn are ignored (dropped, not queued) while Busy=1.
- READY:
  - Write: at an edge with WrEn=1, Busy=0, WrAddr<DEPTH, lanes with WrBe[i]=1 are updated and other lanes keep their value.
  - WrBe=0 is a legal no-op.
  - Read: a request accepted at edge N (RdEn=1, Busy=0) gives RdData valid and RdValid=1 after edge N+RD_LAT. RdValid lasts one cycle.
  - Back-to-back reads sustain one result per cycle at either latency.
- Out of range (address >= DEPTH): the write is discarded. The read completes normally with RdData=0 and RdValid=1.
- Collision (accepted read and write to the same address at the same edge):
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: new bytes where WrBe is set, old bytes elsewhere.
  - For RD_LAT=2, the word is captured at the accept edge; a write at the next edge does not alter the in-flight read.
- Reset mid-operation:
  - Aborts the sweep and restarts it from address 0.
  - Kills in-flight reads; no RdValid is issued for them.
  - Array contents are then re-zeroed by the sweep.

Optional Feature:
- Macro RAM_SDP_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, computed on write and written as 0 (consistent with zero data) by the sweep.
  - Adds input WrParInj (1 bit); when high with a write, it inverts the stored parity of every written lane.
  - Adds output RdParErr (1 bit), reset 0, asserted in the RdValid cycle when any lane of the read word mismatches its parity. It is never asserted on out-of-range reads.
- Undefined: no parity storage and neither extra port exists.

Decomposition:
- Package ram_pkg holds:
  - the state typedef (INIT, READY)
  - the RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants
  - a function computing NB and checking parameter legality (WIDTH % BYTE_WD == 0, RD_LAT in {1,2}, 2^ADD_WD >= DEPTH).
- One sub-module, ram_init_seq: the clear-sweep counter and FSM, producing Busy, sweep address and sweep write strobe.
- The top muxes the sweep write onto the array write port.

Test Plan:
1. Reset sweep: pulse RST for 2 cycles, DEPTH=8 -> Busy high for exactly 8 cycles after release; then reading all addresses 0..7 returns 0x0000 with a RdValid pulse each.
2. Byte enables: write 0x1234 to address 4 with WrBe=11, then 0xABCD to address 4 with WrBe=01; read 4 -> 0x12CD. With RD_LAT=2, RdValid appears 2 edges after the accept.
3. Collision: preload address 1 with 0x0015, then write 0x0023 and read at address 1 in the same cycle -> RDW_MODE=0 returns 0x0015, RDW_MODE=1 returns 0x0023; a following read returns 0x0023.
4. Busy drop: assert WrEn to address 2 with 0xFFFF during the sweep; read 2 after READY -> 0x0000. A read issued during Busy gives no RdValid.
5. Out of range: DEPTH=6, ADD_WD=3; write 0x5555 to address 7, read 7 -> RdData=0x0000 with RdValid=1. Addresses 0..5 are unchanged.
6. Parity (RAM_SDP_PARITY_EN): write 0x00FF with WrParInj=1 to address 3; read 3 -> RdParErr=1 with RdValid. Rewrite with WrParInj=0; read -> RdParErr=0.
